// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter behind a Wishbone slave port.
// Runs request-to-send, shifts a byte with odd parity, checks the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK,
    input  logic        kbd_clk_i,
    input  logic        kbd_data_i,
    output logic        kbd_clk_oe,
    output logic        kbd_data_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACKWAIT,
        S_RELEASE
    } state_t;

    localparam int unsigned CNT_MAX =
        (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    edge_q, edge_d;
    logic [7:0]    byte_q, byte_d;
    logic          ack_ok_q, ack_ok_d;
    logic          err_q, err_d;
    logic          ovr_q, ovr_d;
    logic          ack_q, ack_d;
    logic [3:0]    dat_q, dat_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;

    logic kc_s1_q, kc_s2_q, kc_prev_q;
    logic kd_s1_q, kd_s2_q;

    logic       fall;
    logic [3:0] nxt_edge;
    logic       accept;
    logic       wr;
    logic       busy;
    logic       timeout;
    logic       unused_dat;

    assign fall     = kc_prev_q & ~kc_s2_q;
    assign nxt_edge = edge_q + 4'd1;
    assign accept   = STB & ~ack_q;
    assign wr       = accept & WE;
    assign busy     = (state_q != S_IDLE);
    assign timeout  = (cnt_q == TO_LAST);

    assign unused_dat = ^DAT_I[31:8];

    assign ACK         = ack_q;
    assign DAT_O       = {28'b0, dat_q};
    assign kbd_clk_oe  = clk_oe_q;
    assign kbd_data_oe = data_oe_q;

    // State register, synchronizers and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            byte_q    <= '0;
            ack_ok_q  <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            kc_s1_q   <= 1'b1;
            kc_s2_q   <= 1'b1;
            kc_prev_q <= 1'b1;
            kd_s1_q   <= 1'b1;
            kd_s2_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            byte_q    <= byte_d;
            ack_ok_q  <= ack_ok_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            kc_s1_q   <= kbd_clk_i;
            kc_s2_q   <= kc_s1_q;
            kc_prev_q <= kc_s2_q;
            kd_s1_q   <= kbd_data_i;
            kd_s2_q   <= kd_s1_q;
        end
    end

    // Next state, counters and sticky status
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        edge_d   = edge_q;
        byte_d   = byte_q;
        ack_ok_d = ack_ok_q;
        err_d    = err_q;
        ovr_d    = ovr_q;
        case (state_q)
            S_IDLE: begin
                if (wr) begin
                    byte_d   = DAT_I[7:0];
                    ack_ok_d = 1'b0;
                    err_d    = 1'b0;
                    ovr_d    = 1'b0;
                    cnt_d    = '0;
                    edge_d   = '0;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_REQ, S_SHIFT, S_ACKWAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (fall) begin
                    edge_d = nxt_edge;
                    if (state_q == S_REQ) begin
                        state_d = S_SHIFT;
                    end else if (state_q == S_SHIFT) begin
                        if (nxt_edge == 4'd10) state_d = S_ACKWAIT;
                    end else begin
                        // Edge 11: device drives its ACK bit low
                        if (kd_s2_q) err_d = 1'b1;
                        else ack_ok_d = 1'b1;
                        state_d = S_RELEASE;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RELEASE: begin
                if (kc_s2_q && kd_s2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (wr && busy) ovr_d = 1'b1;
    end

    // Registered line enables, bus acknowledge and status capture
    always_comb begin
        ack_d    = accept;
        dat_d    = dat_q;
        if (accept) dat_d = {ovr_q, err_q, ack_ok_q, busy};
        clk_oe_d  = (state_d == S_INHIBIT);
        data_oe_d = data_oe_q;
        case (state_q)
            S_INHIBIT: data_oe_d = (state_d == S_REQ);
            S_REQ, S_SHIFT: begin
                if (fall) begin
                    if (nxt_edge <= 4'd8) data_oe_d = ~byte_q[edge_q[2:0]];
                    else if (nxt_edge == 4'd9) data_oe_d = ^byte_q;
                    else data_oe_d = 1'b0;
                end
            end
            default: data_oe_d = 1'b0;
        endcase
        if (state_d == S_IDLE) data_oe_d = 1'b0;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: bus tasks plus a PS/2 device model.
// Expected frame bits and status words are queued and checked by monitors.
module tb_ps2_host_tx;

    localparam int INH  = 50;
    localparam int TO   = 3000;
    localparam int HALF = 20;

    logic        clk;
    logic        reset;
    logic        STB;
    logic        WE;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK;
    logic        kbd_clk_i;
    logic        kbd_data_i;
    logic        kbd_clk_oe;
    logic        kbd_data_oe;
    logic        dev_clk_low;
    logic        dev_data_low;

    int n_cmp = 0;
    int n_err = 0;
    int clk_run = 0;
    int data_run = 0;
    int inh_len = 0;
    int data_len = 0;

    logic       exp_bits[$];
    logic [3:0] exp_stat[$];
    event       bit_ev;

    assign kbd_clk_i  = ~(kbd_clk_oe | dev_clk_low);
    assign kbd_data_i = ~(kbd_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .STB(STB),
        .WE(WE),
        .DAT_I(DAT_I),
        .DAT_O(DAT_O),
        .ACK(ACK),
        .kbd_clk_i(kbd_clk_i),
        .kbd_data_i(kbd_data_i),
        .kbd_clk_oe(kbd_clk_oe),
        .kbd_data_oe(kbd_data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Run lengths of the line enables, taken on the falling clk edge
    always @(negedge clk) begin
        if (kbd_clk_oe) clk_run++;
        else if (clk_run != 0) begin
            inh_len = clk_run;
            clk_run = 0;
        end
        if (kbd_data_oe) data_run++;
        else if (data_run != 0) begin
            data_len = data_run;
            data_run = 0;
        end
    end

    // Status monitor: every read acknowledge consumes one expected word
    always @(negedge clk) begin
        if (ACK && !WE) begin
            if (exp_stat.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL status_extra: got 0x%0h expected none", DAT_O);
            end else begin
                check("status", DAT_O, {28'b0, exp_stat.pop_front()});
            end
        end
    end

    // Frame monitor: each device sample consumes one expected bit
    always @(bit_ev) begin
        if (exp_bits.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL bit_extra: got %0b expected none", kbd_data_i);
        end else begin
            check("frame_bit", kbd_data_i, exp_bits.pop_front());
        end
    end

    task automatic push_frame(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) exp_bits.push_back(f[i]);
    endtask

    task automatic bus_op(input logic we, input logic [7:0] b);
        int t;
        @(posedge clk);
        #1;
        STB   = 1'b1;
        WE    = we;
        DAT_I = {24'h0, b};
        t = 0;
        @(negedge clk);
        while (!ACK && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ack_wait", ACK, 1);
        @(posedge clk);
        #1;
        STB = 1'b0;
        @(negedge clk);
        check("ack_pulse", ACK, 0);
        WE = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] b);
        bus_op(1'b1, b);
    endtask

    task automatic bus_read(input logic [3:0] e);
        exp_stat.push_back(e);
        bus_op(1'b0, 8'h00);
    endtask

    // Device model: waits for the request, samples start bit and the
    // line after each rising edge, optionally ACKs on edge 11.
    task automatic device(input int nedge, input bit nack, input int abort_at);
        int t;
        t = 0;
        @(negedge clk);
        while (!(kbd_data_oe && !kbd_clk_oe) && t < 4 * INH) begin
            @(negedge clk);
            t++;
        end
        check("req_seen", {kbd_clk_oe, kbd_data_oe}, 2'b01);
        if (t >= 4 * INH) return;
        @(negedge clk);
        check("inhibit_len", inh_len, INH);
        -> bit_ev;
        for (int k = 1; k <= nedge; k++) begin
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            if (k == 11 && !nack) dev_data_low = 1'b1;
            if (k == abort_at) return;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) -> bit_ev;
        end
        dev_data_low = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        STB          = 1'b0;
        WE           = 1'b0;
        DAT_I        = '0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_clk_oe", kbd_clk_oe, 0);
        check("rst_data_oe", kbd_data_oe, 0);
        check("rst_ack", ACK, 0);
        check("rst_dat", DAT_O, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_read(4'h0);

        // 0xED with device ACK
        push_frame(11'b11111011010, 11);
        bus_write(8'hED);
        device(11, 1'b0, 0);
        repeat (10) @(negedge clk);
        bus_read(4'h2);

        // 0x07 with device NACK
        push_frame(11'b10000001110, 11);
        bus_write(8'h07);
        device(11, 1'b1, 0);
        repeat (10) @(negedge clk);
        bus_read(4'h4);

        // 0x55 with a silent device
        push_frame(11'b11010101010, 1);
        bus_write(8'h55);
        device(0, 1'b0, 0);
        repeat (TO + 20) @(negedge clk);
        check("to_req_len", data_len, TO);
        check("to_clk_oe", kbd_clk_oe, 0);
        check("to_data_oe", kbd_data_oe, 0);
        bus_read(4'h4);

        // 0xF4, with a second write landing mid-frame
        push_frame(11'b10111101000, 11);
        bus_write(8'hF4);
        fork
            device(11, 1'b0, 0);
            begin
                repeat (INH + 150) @(negedge clk);
                bus_write(8'hAA);
            end
        join
        repeat (10) @(negedge clk);
        bus_read(4'hA);

        // 0xAA accepted now, overrun cleared
        push_frame(11'b11101010100, 11);
        bus_write(8'hAA);
        device(11, 1'b0, 0);
        repeat (10) @(negedge clk);
        bus_read(4'h2);

        // 0x35 interrupted by reset after edge 4
        push_frame(11'b11001101010, 4);
        bus_write(8'h35);
        device(11, 1'b0, 4);
        repeat (5) @(negedge clk);
        check("pre_rst_data_oe", kbd_data_oe, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_clk_oe", kbd_clk_oe, 0);
        check("mid_rst_data_oe", kbd_data_oe, 0);
        check("mid_rst_dat", DAT_O, 0);
        reset       = 1'b0;
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        bus_read(4'h0);

        // 0xFF after the interrupted transfer
        push_frame(11'b11111111110, 11);
        bus_write(8'hFF);
        device(11, 1'b0, 0);
        repeat (10) @(negedge clk);
        bus_read(4'h2);

        repeat (5) @(negedge clk);
        check("bits_left", exp_bits.size(), 0);
        check("stat_left", exp_stat.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter, exposed as a Wishbone slave on the CPU bus. It is the send direction complementing the keyboard receive path.
- The CPU writes a command byte (e.g. 0xED set-LEDs, 0xFF reset). The block runs the PS/2 host request-to-send sequence, shifts out the byte with odd parity, and checks the device ACK bit.
- It drives kbd_clk/kbd_data as open-drain (pull-low enables only) alongside the existing keyboard receiver.

Parameters:
- INHIBIT_CYCLES, 10000: clk cycles kbd_clk is held low before request (100 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: max clk cycles from end of inhibit to ACK bit before abort (20 ms).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- STB  in  1  bus strobe, held by master until ACK
- WE  in  1  1 = write, 0 = read
- DAT_I  in  32  write data; [7:0] = byte to send
- DAT_O  out  32  status word
- ACK  out  1  bus acknowledge
- kbd_clk_i  in  1  PS/2 clock line level
- kbd_data_i  in  1  PS/2 data line level
- kbd_clk_oe  out  1  1 = pull PS/2 clock low
- kbd_data_oe  out  1  1 = pull PS/2 data low

Behaviour:
- Reset is synchronous, active-high. On reset: state IDLE, ACK=0, kbd_clk_oe=0, kbd_data_oe=0, all status bits 0, counters 0. Reset mid-transfer releases both lines on the next clk edge and drops the byte.
- Bus: ACK is registered. It goes high the cycle after a cycle with STB=1 and ACK=0, and stays high exactly 1 cycle. One ACK per strobe.
- Write (WE=1):
  - If IDLE, latch DAT_I[7:0], clear bits 1-3, enter INHIBIT.
  - If busy, the byte is dropped and overrun is set.
- Read (WE=0): DAT_O = {28'b0, overrun, error, ack_ok, busy}. DAT_O is valid whenever ACK=1; it is 0 on reset.
- busy = (state != IDLE).
- Line inputs pass through 2-FF synchronizers. A falling edge is synced_prev=1 and synced=0. Edge effects land 3 cycles after the pin edge.
- FSM:
  - IDLE: lines released.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles. In the last cycle, set data_oe=1 (start bit) and go to REQ.
  - REQ: clk_oe=0, data_oe=1. Start the timeout counter. Wait for falling edge 1, then go to SHIFT.
  - SHIFT: on falling edges 1..8, drive data_oe = ~byte[n], LSB first (edge1 -> bit0).
  - On falling edge 9: data_oe = ~parity, where parity = ~^byte (odd).
  - On falling edge 10: data_oe=0 (stop bit, released). Go to ACKWAIT.
  - ACKWAIT: on falling edge 11, sample synced data. 0 -> ack_ok=1. 1 -> error=1 (NACK). Go to RELEASE.
  - RELEASE: wait until synced clk=1 and data=1, then go to IDLE.
- Timeout: the counter runs from REQ entry until falling edge 11. When it reaches TIMEOUT_CYCLES: error=1, both oe=0, go to IDLE, ack_ok stays 0.
- The edge counter is 4 bits and is cleared on INHIBIT entry. Edges seen in IDLE/INHIBIT/RELEASE are ignored.
- A write in the same cycle the FSM returns to IDLE counts as busy, so overrun is set.
- Status bits 1-3 are sticky. They clear only on reset or on an accepted write. Reads do not clear them.
- kbd_clk_oe and kbd_data_oe are registered outputs, glitch-free.

Test Plan:
- Reset: hold reset 3 cycles with lines high -> oe outputs 0, ACK 0, read status = 0x0, busy=0.
- Send 0xED; device model clocks 11 falling edges ~40 us apart and pulls data low at edge 11:
  - clk_oe high for exactly INHIBIT_CYCLES.
  - Bits observed at rising edges: 0 (start), 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Final status = 0x2 (ack_ok).
- Send 0x07 -> bits 1,1,1,0,0,0,0,0, parity 0. Device leaves data high at edge 11 -> status = 0x4 (error, no ack_ok).
- Timeout: send 0x55, device never clocks. After TIMEOUT_CYCLES from REQ entry: both oe=0, status = 0x4, busy=0.
- Overrun: write 0xF4, then write 0xAA during SHIFT:
  - 0xF4 completes with correct bits.
  - Read status = 0xA (overrun, ack_ok).
  - A subsequent write of 0xAA clears bit 3.
- Reset mid-SHIFT after edge 4 -> next cycle both oe=0, status 0. A new write of 0xFF transmits normally (parity 1).
